// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot state encoding, parity-mode codes and default
// frame parameters, common to the transmitter and the matching receiver.
`timescale 1ns/1ps
package uart_pkg;

    localparam int DEF_WIDTH_WORD    = 8;
    localparam int DEF_CANT_BIT_STOP = 2;
    localparam int DEF_OVERSAMPLE    = 16;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_START  = 5'b00010,
        ST_DATA   = 5'b00100,
        ST_PARITY = 5'b01000,
        ST_STOP   = 5'b10000
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Mode 2'b11 is reserved and behaves as no parity.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Words narrower than 9 bits are zero-extended, which leaves the XOR unchanged.
    function automatic logic parity_value(input logic [8:0] data, input logic [1:0] mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Request/serial-line bundle between the command logic, the baud generator and the
// transmitter; master drives the request side, slave is the transmitter.
`timescale 1ns/1ps
interface uart_tx_param_if import uart_pkg::*; #(
    parameter int WIDTH_WORD = DEF_WIDTH_WORD
);

    logic                  i_tick;
    logic [WIDTH_WORD-1:0] i_data_in;
    logic [1:0]            i_parity_mode;
    logic                  i_tx_start;
    logic                  o_bit_tx;
    logic                  o_busy;
    logic                  o_tx_done;

    modport master (
        output i_tick, i_data_in, i_parity_mode, i_tx_start,
        input  o_bit_tx, o_busy, o_tx_done
    );

    modport slave (
        input  i_tick, i_data_in, i_parity_mode, i_tx_start,
        output o_bit_tx, o_busy, o_tx_done
    );

endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, LSB-first data, optional parity and
// 1-2 stop bits, each bit lasting OVERSAMPLE ticks of the baud enable.
`timescale 1ns/1ps
module uart_tx_param import uart_pkg::*; #(
    parameter int WIDTH_WORD    = DEF_WIDTH_WORD,
    parameter int CANT_BIT_STOP = DEF_CANT_BIT_STOP,
    parameter int OVERSAMPLE    = DEF_OVERSAMPLE
) (
    input  logic           i_clk,
    input  logic           i_reset,
    uart_tx_param_if.slave tx_if
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(WIDTH_WORD + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH_WORD - 1);
    localparam logic              STOP_LAST = 1'(CANT_BIT_STOP - 1);

    if (WIDTH_WORD < 5 || WIDTH_WORD > 9) begin : g_chk_width
        $error("uart_tx_param: WIDTH_WORD must be in 5..9");
    end
    if (CANT_BIT_STOP < 1 || CANT_BIT_STOP > 2) begin : g_chk_stop
        $error("uart_tx_param: CANT_BIT_STOP must be 1 or 2");
    end
    if (OVERSAMPLE < 2) begin : g_chk_os
        $error("uart_tx_param: OVERSAMPLE must be at least 2");
    end

    state_t                state,    state_nxt;
    logic [TICK_W-1:0]     tick_cnt, tick_nxt;
    logic [BIT_W-1:0]      bit_cnt,  bit_nxt;
    logic                  stop_cnt, stop_nxt;
    logic [WIDTH_WORD-1:0] shift_reg, shift_nxt;
    logic                  par_en,   par_en_nxt;
    logic                  par_bit,  par_bit_nxt;
    logic                  bit_tx,   bit_tx_nxt;
    logic                  busy,     busy_nxt;
    logic                  tx_done,  tx_done_nxt;
    logic                  bit_end;

    assign bit_end = tx_if.i_tick && (tick_cnt == TICK_LAST);

    always_comb begin
        state_nxt   = state;
        tick_nxt    = tick_cnt;
        bit_nxt     = bit_cnt;
        stop_nxt    = stop_cnt;
        shift_nxt   = shift_reg;
        par_en_nxt  = par_en;
        par_bit_nxt = par_bit;
        bit_tx_nxt  = bit_tx;
        busy_nxt    = busy;
        tx_done_nxt = 1'b0;

        // The bit timer only runs inside a frame; IDLE holds it at zero.
        if (state != ST_IDLE && tx_if.i_tick) begin
            tick_nxt = bit_end ? '0 : tick_cnt + TICK_W'(1);
        end

        unique case (state)
            ST_IDLE: begin
                if (tx_if.i_tx_start) begin
                    shift_nxt   = tx_if.i_data_in;
                    par_en_nxt  = parity_enabled(tx_if.i_parity_mode);
                    par_bit_nxt = parity_value(9'(tx_if.i_data_in), tx_if.i_parity_mode);
                    tick_nxt    = '0;
                    bit_nxt     = '0;
                    stop_nxt    = 1'b0;
                    bit_tx_nxt  = 1'b0;
                    busy_nxt    = 1'b1;
                    state_nxt   = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bit_tx_nxt = shift_reg[0];
                    state_nxt  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    bit_nxt   = bit_cnt + BIT_W'(1);
                    shift_nxt = shift_reg >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        if (par_en) begin
                            bit_tx_nxt = par_bit;
                            state_nxt  = ST_PARITY;
                        end else begin
                            bit_tx_nxt = 1'b1;
                            state_nxt  = ST_STOP;
                        end
                    end else begin
                        bit_tx_nxt = shift_reg[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    bit_tx_nxt = 1'b1;
                    state_nxt  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop_cnt == STOP_LAST) begin
                        stop_nxt    = 1'b0;
                        busy_nxt    = 1'b0;
                        tx_done_nxt = 1'b1;
                        state_nxt   = ST_IDLE;
                    end else begin
                        stop_nxt = 1'b1;
                    end
                end
            end
            default: begin
                bit_tx_nxt = 1'b1;
                busy_nxt   = 1'b0;
                state_nxt  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state     <= ST_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            shift_reg <= '0;
            par_en    <= 1'b0;
            par_bit   <= 1'b0;
            bit_tx    <= 1'b1;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_nxt;
            tick_cnt  <= tick_nxt;
            bit_cnt   <= bit_nxt;
            stop_cnt  <= stop_nxt;
            shift_reg <= shift_nxt;
            par_en    <= par_en_nxt;
            par_bit   <= par_bit_nxt;
            bit_tx    <= bit_tx_nxt;
            busy      <= busy_nxt;
            tx_done   <= tx_done_nxt;
        end
    end

    assign tx_if.o_bit_tx  = bit_tx;
    assign tx_if.o_busy    = busy;
    assign tx_if.o_tx_done = tx_done;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four parameterisations share one clock and are
// exercised with hand-computed frame bit patterns and tick counts.
`timescale 1ns/1ps
module tb_uart_tx_param;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick_div = 1'b0;
    int unsigned div_cnt = 0;
    int          checks = 0;
    int          passes = 0;

    always #5 clk = ~clk;

    // Baud enable: one-cycle pulse every third clock, changing away from the active edge.
    always @(negedge clk) begin
        div_cnt  = (div_cnt == 2) ? 0 : div_cnt + 1;
        tick_div = (div_cnt == 0);
    end

    uart_tx_param_if #(.WIDTH_WORD(8)) if_a ();
    uart_tx_param_if #(.WIDTH_WORD(8)) if_b ();
    uart_tx_param_if #(.WIDTH_WORD(5)) if_c ();
    uart_tx_param_if #(.WIDTH_WORD(8)) if_d ();

    assign if_a.i_tick = tick_div;
    assign if_b.i_tick = tick_div;
    assign if_c.i_tick = tick_div;
    assign if_d.i_tick = 1'b1;

    uart_tx_param #(.WIDTH_WORD(8), .CANT_BIT_STOP(1), .OVERSAMPLE(16)) dut_a (
        .i_clk(clk), .i_reset(rst_n), .tx_if(if_a));
    uart_tx_param #(.WIDTH_WORD(8), .CANT_BIT_STOP(2), .OVERSAMPLE(16)) dut_b (
        .i_clk(clk), .i_reset(rst_n), .tx_if(if_b));
    uart_tx_param #(.WIDTH_WORD(5), .CANT_BIT_STOP(1), .OVERSAMPLE(4)) dut_c (
        .i_clk(clk), .i_reset(rst_n), .tx_if(if_c));
    uart_tx_param #(.WIDTH_WORD(8), .CANT_BIT_STOP(1), .OVERSAMPLE(2)) dut_d (
        .i_clk(clk), .i_reset(rst_n), .tx_if(if_d));

    task automatic sample(input int sel, output logic tk, output logic line,
                          output logic bsy, output logic dn);
        case (sel)
            0:       begin tk = if_a.i_tick; line = if_a.o_bit_tx; bsy = if_a.o_busy; dn = if_a.o_tx_done; end
            1:       begin tk = if_b.i_tick; line = if_b.o_bit_tx; bsy = if_b.o_busy; dn = if_b.o_tx_done; end
            2:       begin tk = if_c.i_tick; line = if_c.o_bit_tx; bsy = if_c.o_busy; dn = if_c.o_tx_done; end
            default: begin tk = if_d.i_tick; line = if_d.o_bit_tx; bsy = if_d.o_busy; dn = if_d.o_tx_done; end
        endcase
    endtask

    task automatic drive(input int sel, input logic st, input logic [8:0] data, input logic [1:0] mode);
        case (sel)
            0:       begin if_a.i_tx_start = st; if_a.i_data_in = data[7:0]; if_a.i_parity_mode = mode; end
            1:       begin if_b.i_tx_start = st; if_b.i_data_in = data[7:0]; if_b.i_parity_mode = mode; end
            2:       begin if_c.i_tx_start = st; if_c.i_data_in = data[4:0]; if_c.i_parity_mode = mode; end
            default: begin if_d.i_tx_start = st; if_d.i_data_in = data[7:0]; if_d.i_parity_mode = mode; end
        endcase
    endtask

    // Raise start at a falling edge; returns just after the accepting rising edge.
    task automatic kick(input int sel, input logic [8:0] data, input logic [1:0] mode, input bit hold);
        @(negedge clk);
        drive(sel, 1'b1, data, mode);
        @(posedge clk); #1;
        if (!hold) drive(sel, 1'b0, data, mode);
    endtask

    // Records the line at the first and last clock of every bit, counted in ticks after
    // the accepting edge, until the done pulse. Optionally re-pulses start mid-frame.
    task automatic capture(input int sel, input int os, input int nbits, input int poke_cnt,
                           output logic [15:0] firstv, output logic [15:0] lastv,
                           output int done_cnt, output logic busy_ok, output logic end_ok);
        logic tk, line, bsy, dn;
        int   cnt;
        int   k;
        bit   poked;
        firstv   = 16'hxxxx;
        lastv    = 16'hxxxx;
        cnt      = 0;
        done_cnt = -1;
        end_ok   = 1'b0;
        poked    = 1'b0;
        sample(sel, tk, line, bsy, dn);
        busy_ok   = (bsy === 1'b1);
        firstv[0] = line;
        lastv[0]  = line;
        for (int cyc = 0; cyc < os * nbits * 4 + 64; cyc++) begin
            @(posedge clk); #1;
            if (poked) drive(sel, 1'b0, 9'h1FF, PAR_EVEN);
            sample(sel, tk, line, bsy, dn);
            if (tk) cnt++;
            if (dn === 1'b1) begin
                done_cnt = cnt;
                end_ok   = (line === 1'b1) && (bsy === 1'b0);
                break;
            end
            if (bsy !== 1'b1) busy_ok = 1'b0;
            k = cnt / os;
            if (k < nbits) begin
                if (tk && (cnt % os == 0)) firstv[k] = line;
                lastv[k] = line;
            end
            if (poke_cnt >= 0 && cnt == poke_cnt && !poked) begin
                drive(sel, 1'b1, 9'h1FF, PAR_EVEN);
                poked = 1'b1;
            end
        end
        for (int i = nbits; i < 16; i++) begin
            firstv[i] = 1'b0;
            lastv[i]  = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic tk, line, bsy, dn;
        rst_n = 1'b0;
        for (int s = 0; s < 4; s++) drive(s, 1'b0, 9'h000, PAR_NONE);
        drive(0, 1'b1, 9'h0FF, PAR_NONE);
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            sample(s, tk, line, bsy, dn);
            checks++;
            if ({line, bsy, dn} !== 3'b100)
                $display("FAIL reset_state dut%0d: line/busy/done got %b%b%b expected 100", s, line, bsy, dn);
            else passes++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b0, 9'h000, PAR_NONE);
        @(posedge clk); #1;
        sample(0, tk, line, bsy, dn);
        checks++;
        if ({line, bsy} !== 2'b10)
            $display("FAIL reset_release: line/busy got %b%b expected 10", line, bsy);
        else passes++;
    endtask

    task automatic test_8n1();
        logic [15:0] fv, lv;
        int          dc;
        logic        bok, eok, tk, line, bsy, dn;
        kick(0, 9'h055, PAR_NONE, 1'b0);
        capture(0, 16, 10, -1, fv, lv, dc, bok, eok);
        checks++; if (fv !== 16'h02AA) $display("FAIL 8n1_first: got %h expected 02aa", fv); else passes++;
        checks++; if (lv !== 16'h02AA) $display("FAIL 8n1_last: got %h expected 02aa", lv); else passes++;
        checks++; if (dc !== 160) $display("FAIL 8n1_done_ticks: got %0d expected 160", dc); else passes++;
        checks++; if (bok !== 1'b1) $display("FAIL 8n1_busy: got %b expected 1", bok); else passes++;
        checks++; if (eok !== 1'b1) $display("FAIL 8n1_end_state: got %b expected 1", eok); else passes++;
        @(posedge clk); #1;
        sample(0, tk, line, bsy, dn);
        checks++; if (dn !== 1'b0) $display("FAIL 8n1_done_width: got %b expected 0", dn); else passes++;
    endtask

    task automatic test_parity();
        logic [15:0] fv, lv;
        int          dc;
        logic        bok, eok;
        kick(1, 9'h007, PAR_EVEN, 1'b0);
        capture(1, 16, 12, -1, fv, lv, dc, bok, eok);
        checks++; if (fv !== 16'h0E0E || lv !== 16'h0E0E)
            $display("FAIL 8e2_bits: got %h/%h expected 0e0e", fv, lv); else passes++;
        checks++; if (dc !== 192) $display("FAIL 8e2_done_ticks: got %0d expected 192", dc); else passes++;

        kick(1, 9'h007, PAR_ODD, 1'b0);
        capture(1, 16, 12, -1, fv, lv, dc, bok, eok);
        checks++; if (fv !== 16'h0C0E || lv !== 16'h0C0E)
            $display("FAIL 8o2_bits: got %h/%h expected 0c0e", fv, lv); else passes++;
        checks++; if (dc !== 192) $display("FAIL 8o2_done_ticks: got %0d expected 192", dc); else passes++;

        kick(1, 9'h007, 2'b11, 1'b0);
        capture(1, 16, 11, -1, fv, lv, dc, bok, eok);
        checks++; if (fv !== 16'h060E || lv !== 16'h060E)
            $display("FAIL mode11_bits: got %h/%h expected 060e", fv, lv); else passes++;
        checks++; if (dc !== 176) $display("FAIL mode11_done_ticks: got %0d expected 176", dc); else passes++;
        checks++; if (bok !== 1'b1 || eok !== 1'b1)
            $display("FAIL mode11_busy_end: got %b%b expected 11", bok, eok); else passes++;
    endtask

    task automatic test_ignore_start();
        logic [15:0] fv, lv;
        int          dc;
        logic        bok, eok, tk, line, bsy, dn;
        kick(0, 9'h055, PAR_NONE, 1'b0);
        capture(0, 16, 10, 16 * 3 + 4, fv, lv, dc, bok, eok);
        checks++; if (fv !== 16'h02AA || lv !== 16'h02AA)
            $display("FAIL ignore_bits: got %h/%h expected 02aa", fv, lv); else passes++;
        checks++; if (dc !== 160) $display("FAIL ignore_done_ticks: got %0d expected 160", dc); else passes++;
        checks++; if (bok !== 1'b1) $display("FAIL ignore_busy: got %b expected 1", bok); else passes++;
        repeat (4) @(posedge clk);
        #1;
        sample(0, tk, line, bsy, dn);
        checks++; if ({line, bsy} !== 2'b10)
            $display("FAIL ignore_not_queued: line/busy got %b%b expected 10", line, bsy); else passes++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] fv, lv;
        int          dc, cnt;
        bit          seen_done, seen_busy;
        logic        bok, eok, tk, line, bsy, dn;
        kick(0, 9'h000, PAR_NONE, 1'b0);
        cnt = 0;
        for (int cyc = 0; cyc < 400 && cnt < 16 * 3 + 5; cyc++) begin
            @(posedge clk); #1;
            sample(0, tk, line, bsy, dn);
            if (tk) cnt++;
        end
        checks++; if (cnt !== 53) $display("FAIL resetmid_reach_bit3: ticks got %0d expected 53", cnt); else passes++;
        checks++; if (line !== 1'b0) $display("FAIL resetmid_line_before: got %b expected 0", line); else passes++;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        sample(0, tk, line, bsy, dn);
        checks++; if ({line, bsy, dn} !== 3'b100)
            $display("FAIL resetmid_state: line/busy/done got %b%b%b expected 100", line, bsy, dn); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        seen_busy = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            sample(0, tk, line, bsy, dn);
            if (dn === 1'b1) seen_done = 1'b1;
            if (bsy !== 1'b0) seen_busy = 1'b1;
        end
        checks++; if ({seen_done, seen_busy} !== 2'b00)
            $display("FAIL resetmid_quiet: done/busy seen %b%b expected 00", seen_done, seen_busy); else passes++;
        kick(0, 9'h0A3, PAR_NONE, 1'b0);
        capture(0, 16, 10, -1, fv, lv, dc, bok, eok);
        checks++; if (fv !== 16'h0346 || lv !== 16'h0346)
            $display("FAIL resetmid_fresh_bits: got %h/%h expected 0346", fv, lv); else passes++;
        checks++; if (dc !== 160) $display("FAIL resetmid_fresh_ticks: got %0d expected 160", dc); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] fv, lv;
        int          dc;
        logic        bok, eok, tk, line, bsy, dn;
        kick(2, 9'h016, PAR_NONE, 1'b1);
        capture(2, 4, 7, -1, fv, lv, dc, bok, eok);
        checks++; if (fv !== 16'h006C || lv !== 16'h006C)
            $display("FAIL b2b_first_bits: got %h/%h expected 006c", fv, lv); else passes++;
        checks++; if (dc !== 28) $display("FAIL b2b_first_ticks: got %0d expected 28", dc); else passes++;
        checks++; if (eok !== 1'b1) $display("FAIL b2b_idle_on_done: got %b expected 1", eok); else passes++;
        @(posedge clk); #1;
        sample(2, tk, line, bsy, dn);
        checks++; if ({line, bsy} !== 2'b01)
            $display("FAIL b2b_restart: line/busy got %b%b expected 01", line, bsy); else passes++;
        drive(2, 1'b0, 9'h016, PAR_NONE);
        capture(2, 4, 7, -1, fv, lv, dc, bok, eok);
        checks++; if (fv !== 16'h006C || lv !== 16'h006C)
            $display("FAIL b2b_second_bits: got %h/%h expected 006c", fv, lv); else passes++;
        checks++; if (dc !== 28) $display("FAIL b2b_second_ticks: got %0d expected 28", dc); else passes++;
    endtask

    task automatic test_tick_high();
        logic [15:0] fv, lv;
        int          dc;
        logic        bok, eok;
        kick(3, 9'h0A3, PAR_NONE, 1'b0);
        capture(3, 2, 10, -1, fv, lv, dc, bok, eok);
        checks++; if (fv !== 16'h0346 || lv !== 16'h0346)
            $display("FAIL tickhigh_bits: got %h/%h expected 0346", fv, lv); else passes++;
        checks++; if (dc !== 20) $display("FAIL tickhigh_done_ticks: got %0d expected 20", dc); else passes++;
        checks++; if (bok !== 1'b1 || eok !== 1'b1)
            $display("FAIL tickhigh_busy_end: got %b%b expected 11", bok, eok); else passes++;
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_8n1();
        test_parity();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_tick_high();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
